// File: rtl/param_memory.sv
// Parametrised single-port synchronous memory with per-byte enables, 1- or 2-cycle
// read latency, write-first read-during-write and a post-reset initialisation sweep.
module param_memory #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  init_busy,
    output logic                  err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   sweep_cnt_r;
    logic [ADDR_W-1:0]   sweep_cnt_nxt_s;
    logic                in_init_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic [DATA_W-1:0]   wr_word_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                out_vld_s;
    logic [DATA_W-1:0]   out_data_s;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];
    logic [DATA_W-1:0]   data_out_r;
    logic                rd_valid_r;
    logic                init_busy_r;
    logic                err_r;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     byte_en
    );
        logic [DATA_W-1:0] res;
        for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign in_init_s = (state_r == ST_INIT);
    assign wr_acc_s  = wr_en & ~in_init_s;
    assign rd_acc_s  = rd_en & ~in_init_s;
    assign wr_word_s = byte_merge(mem_r[addr], data_in, be);
    // Write-first: a read in the same cycle as an accepted write sees the merged word.
    assign rd_word_s = wr_acc_s ? wr_word_s : mem_r[addr];

    // Next-state logic for the init sweep / serving FSM
    always_comb begin
        state_nxt_s     = state_r;
        sweep_cnt_nxt_s = sweep_cnt_r;
        case (state_r)
            ST_INIT: begin
                sweep_cnt_nxt_s = sweep_cnt_r + ADDR_ONE;
                if (sweep_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s     = ST_INIT;
                sweep_cnt_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM state, sweep counter and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            sweep_cnt_r <= {ADDR_W{1'b0}};
            init_busy_r <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sweep_cnt_r <= sweep_cnt_nxt_s;
            init_busy_r <= (state_nxt_s == ST_INIT);
            err_r       <= in_init_s & (wr_en | rd_en);
        end
    end

    // Storage array; contents survive reset and are rewritten by the sweep
    always_ff @(posedge clk) begin
        if (in_init_s) begin
            mem_r[sweep_cnt_r] <= INIT_VAL;
        end else if (wr_acc_s) begin
            mem_r[addr] <= wr_word_s;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p_valid_r;
            logic [DATA_W-1:0] p_data_r;

            // Extra read stage for the two-cycle latency build
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_valid_r <= 1'b0;
                    p_data_r  <= {DATA_W{1'b0}};
                end else begin
                    p_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        p_data_r <= rd_word_s;
                    end
                end
            end

            assign out_vld_s  = p_valid_r;
            assign out_data_s = p_data_r;
        end else begin : g_lat1
            assign out_vld_s  = rd_acc_s;
            assign out_data_s = rd_word_s;
        end
    endgenerate

    // Output read register; data holds while no read completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            data_out_r <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= out_vld_s;
            if (out_vld_s) begin
                data_out_r <= out_data_s;
            end
        end
    end

    assign data_out  = data_out_r;
    assign rd_valid  = rd_valid_r;
    assign init_busy = init_busy_r;
    assign err       = err_r;

endmodule
